// File: rtl/poly_voice_engine_if.sv
// Note LUT port of poly_voice_engine.
// The engine (master) presents lut_note/lut_octave; the LUT (slave) returns
// lut_div exactly one clock later. There is no valid/ready pair: the request
// is accepted on every rising edge, and the response always lands on the next edge.
interface poly_voice_engine_if #(
    parameter int KEY_IDX_W     = 4,
    parameter int WIDTH_COUNTER = 16
);
    logic [KEY_IDX_W-1:0]     lut_note;
    logic [3:0]               lut_octave;
    logic [WIDTH_COUNTER-1:0] lut_div;

    modport master (output lut_note, output lut_octave, input lut_div);
    modport slave  (input lut_note, input lut_octave, output lut_div);
endinterface

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: polyphonic key scanner, voice allocator, per-voice tone
// dividers and a popcount mixer with PWM output.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a pressed key that
// finds no free voice steals the voice at steal_ptr (round robin).
// The o_dbg_* ports expose FSM state, scan pointer, owners, dividers and steal
// pointer so checkers can observe allocation without probing internals.
module poly_voice_engine #(
    parameter int NUM_KEYS      = 12,
    parameter int NUM_VOICES    = 4,
    parameter int WIDTH_COUNTER = 16,
    parameter int KEY_IDX_W     = $clog2(NUM_KEYS),
    parameter int MIX_W         = $clog2(NUM_VOICES + 1),
    parameter int VOICE_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_KEYS-1:0]                 keys,
    input  logic [3:0]                          octave,
    poly_voice_engine_if.master                 lut,
    output logic [NUM_VOICES-1:0]               voice_active,
    output logic [NUM_VOICES-1:0]               tone,
    output logic [MIX_W-1:0]                    mix,
    output logic                                pwm_out,
    output logic                                o_dbg_state,
    output logic [KEY_IDX_W-1:0]                o_dbg_scan_ptr,
    output logic [NUM_VOICES*KEY_IDX_W-1:0]     o_dbg_owner,
    output logic [NUM_VOICES*WIDTH_COUNTER-1:0] o_dbg_div,
    output logic [VOICE_W-1:0]                  o_dbg_steal_ptr
);
    typedef enum logic {S_CHECK = 1'b0, S_LOAD = 1'b1} state_t;
    typedef enum logic [1:0] {A_NONE = 2'd0, A_ALLOC = 2'd1, A_RELOAD = 2'd2} act_t;

    logic [NUM_KEYS-1:0]      r_ks_meta;
    logic [NUM_KEYS-1:0]      r_ks;
    state_t                   r_state;
    state_t                   w_state_next;
    logic [KEY_IDX_W-1:0]     r_scan_ptr;
    logic [3:0]               r_lut_octave;
    act_t                     r_act;
    act_t                     w_act_next;
    logic [VOICE_W-1:0]       r_act_voice;
    logic [VOICE_W-1:0]       w_act_voice_next;
    logic                     w_do_free;

    logic [NUM_VOICES-1:0]    r_active;
    logic [NUM_VOICES-1:0]    r_tone;
    logic [KEY_IDX_W-1:0]     r_owner [NUM_VOICES];
    logic [WIDTH_COUNTER-1:0] r_div   [NUM_VOICES];
    logic [WIDTH_COUNTER-1:0] r_cnt   [NUM_VOICES];

    logic [MIX_W-1:0]         r_mix;
    logic [MIX_W-1:0]         w_popcnt;
    logic [MIX_W-1:0]         r_pwm_cnt;
    logic                     r_pwm;

    logic                     w_key_pressed;
    logic                     w_owned;
    logic [VOICE_W-1:0]       w_owned_idx;
    logic                     w_any_free;
    logic [VOICE_W-1:0]       w_free_idx;

`ifdef VOICE_STEAL_EN
    logic [VOICE_W-1:0]       r_steal_ptr;
    logic                     r_act_steal;
    logic                     w_steal;
`endif

    assign w_key_pressed = r_ks[r_scan_ptr];

    // Two-flop synchroniser for the asynchronous key levels
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ks_meta <= '0;
            r_ks      <= '0;
        end else begin
            r_ks_meta <= keys;
            r_ks      <= r_ks_meta;
        end
    end

    // Find the voice owning the scanned key and the lowest-index free voice
    always_comb begin
        w_owned     = 1'b0;
        w_owned_idx = '0;
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_owner[v] == r_scan_ptr)) begin
                w_owned     = 1'b1;
                w_owned_idx = VOICE_W'(v);
            end
            if (!r_active[v]) begin
                w_any_free = 1'b1;
                w_free_idx = VOICE_W'(v);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_CHECK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and per-key action decision
    always_comb begin
        w_state_next     = r_state;
        w_act_next       = A_NONE;
        w_act_voice_next = r_act_voice;
        w_do_free        = 1'b0;
`ifdef VOICE_STEAL_EN
        w_steal          = 1'b0;
`endif
        case (r_state)
            S_CHECK: begin
                w_state_next = S_LOAD;
                if (w_owned) begin
                    if (w_key_pressed) begin
                        w_act_next       = A_RELOAD;
                        w_act_voice_next = w_owned_idx;
                    end else begin
                        w_do_free = 1'b1;
                    end
                end else if (w_key_pressed) begin
                    if (w_any_free) begin
                        w_act_next       = A_ALLOC;
                        w_act_voice_next = w_free_idx;
                    end
`ifdef VOICE_STEAL_EN
                    else begin
                        w_act_next       = A_ALLOC;
                        w_act_voice_next = r_steal_ptr;
                        w_steal          = 1'b1;
                    end
`endif
                end
            end
            S_LOAD: begin
                w_state_next = S_CHECK;
            end
            default: begin
                w_state_next = S_CHECK;
            end
        endcase
    end

    // Scan pointer, pending action, LUT octave and steal pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scan_ptr   <= '0;
            r_act        <= A_NONE;
            r_act_voice  <= '0;
            r_lut_octave <= '0;
`ifdef VOICE_STEAL_EN
            r_steal_ptr  <= '0;
            r_act_steal  <= 1'b0;
`endif
        end else begin
            r_act        <= w_act_next;
            r_act_voice  <= w_act_voice_next;
            r_lut_octave <= octave;
`ifdef VOICE_STEAL_EN
            r_act_steal  <= w_steal;
            if ((r_state == S_LOAD) && r_act_steal) begin
                r_steal_ptr <= (r_steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + VOICE_W'(1);
            end
`endif
            if (r_state == S_LOAD) begin
                r_scan_ptr <= (r_scan_ptr == KEY_IDX_W'(NUM_KEYS - 1)) ? '0 : r_scan_ptr + KEY_IDX_W'(1);
            end
        end
    end

    // Per-voice tone dividers plus free/allocate/reload updates from the FSM.
    // The toggle test is >= so that a reload to a smaller divider does not
    // let the counter run on to wrap-around.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active <= '0;
            r_tone   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_owner[v] <= '0;
                r_div[v]   <= '0;
                r_cnt[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_active[v] && (r_div[v] != '0)) begin
                    if (r_cnt[v] >= r_div[v]) begin
                        r_cnt[v]  <= '0;
                        r_tone[v] <= ~r_tone[v];
                    end else begin
                        r_cnt[v] <= r_cnt[v] + WIDTH_COUNTER'(1);
                    end
                end else begin
                    r_cnt[v]  <= '0;
                    r_tone[v] <= 1'b0;
                end
                if (w_do_free && (w_owned_idx == VOICE_W'(v))) begin
                    r_active[v] <= 1'b0;
                    r_tone[v]   <= 1'b0;
                    r_cnt[v]    <= '0;
                end
                if ((r_state == S_LOAD) && (r_act_voice == VOICE_W'(v))) begin
                    if (r_act == A_ALLOC) begin
                        r_owner[v]  <= r_scan_ptr;
                        r_div[v]    <= lut.lut_div;
                        r_active[v] <= 1'b1;
                        r_cnt[v]    <= '0;
                        r_tone[v]   <= 1'b0;
                    end else if (r_act == A_RELOAD) begin
                        r_div[v] <= lut.lut_div;
                    end
                end
            end
        end
    end

    // Count of voices currently high
    always_comb begin
        w_popcnt = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_popcnt = w_popcnt + MIX_W'(r_tone[v]);
        end
    end

    // Registered mix level and PWM of that level over a NUM_VOICES-cycle frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mix     <= '0;
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_mix     <= w_popcnt;
            r_pwm_cnt <= (r_pwm_cnt == MIX_W'(NUM_VOICES - 1)) ? '0 : r_pwm_cnt + MIX_W'(1);
            r_pwm     <= (r_pwm_cnt < r_mix);
        end
    end

    assign lut.lut_note   = r_scan_ptr;
    assign lut.lut_octave = r_lut_octave;
    assign voice_active   = r_active;
    assign tone           = r_tone;
    assign mix            = r_mix;
    assign pwm_out        = r_pwm;
    assign o_dbg_state    = r_state;
    assign o_dbg_scan_ptr = r_scan_ptr;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_dbg
        assign o_dbg_owner[g*KEY_IDX_W +: KEY_IDX_W]         = r_owner[g];
        assign o_dbg_div[g*WIDTH_COUNTER +: WIDTH_COUNTER] = r_div[g];
    end

`ifdef VOICE_STEAL_EN
    assign o_dbg_steal_ptr = r_steal_ptr;
`else
    assign o_dbg_steal_ptr = '0;
`endif
endmodule

// File: doc/poly_voice_engine.md
Name: poly_voice_engine

Overview:
- Polyphonic successor to the single-voice piano path: up to NUM_VOICES keys sound at once instead of one priority-decoded note.
- Scans the synchronised key vector and allocates or frees voices.
- Fetches each voice's divider through the external registered note LUT port (1-cycle latency, same timing as note_lut).
- Runs one tone divider per voice and mixes voices into a level count plus a 1-bit PWM output for uo_out[0].

Parameters:
- NUM_KEYS, 12, number of key inputs; key index k drives lut_note=k.
- NUM_VOICES, 4, number of simultaneous tone generators (≥1).
- WIDTH_COUNTER, 16, width of divider value and per-voice counter.
- KEY_IDX_W, $clog2(NUM_KEYS), width of lut_note and voice owner fields.
- MIX_W, $clog2(NUM_VOICES+1), width of mix output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- keys  input  NUM_KEYS  raw key levels, 1=pressed; asynchronous to clk.
- octave  input  4  octave select, forwarded to LUT.
- lut_note  output  KEY_IDX_W  key index presented to LUT.
- lut_octave  output  4  octave presented to LUT.
- lut_div  input  WIDTH_COUNTER  LUT result, valid 1 cycle after lut_note/lut_octave.
- voice_active  output  NUM_VOICES  1 = voice owned by a key.
- tone  output  NUM_VOICES  per-voice square wave.
- mix  output  MIX_W  count of voices whose tone is 1.
- pwm_out  output  1  PWM of mix.

Behaviour:
- Reset (rstn=0, async): synchroniser flops, voice_active, tone, per-voice counters, divs and owners, mix, pwm_out, pwm counter, scan pointer and steal pointer all 0. lut_note=0, lut_octave=0, FSM=S_CHECK.
- Keys pass a 2-flop synchroniser (ks). Octave is sampled directly.
- FSM, 2 cycles per key:
  - S_CHECK: drive lut_note=scan_ptr, lut_octave=octave. Decide the action for key k=scan_ptr from ks[k] and owner match:
    - owned and ks[k]=0 → free the voice: voice_active←0, tone←0, counter←0.
    - owned and ks[k]=1 → mark reload.
    - not owned and ks[k]=1 → mark allocate to the lowest-index inactive voice; if none is free, no action (or steal, see Optional Feature).
    - Go to S_LOAD.
  - S_LOAD: apply the marked action using lut_div:
    - allocate: owner←k, div←lut_div, active←1, counter←0, tone←0.
    - reload: div←lut_div only; counter and tone keep running.
    - scan_ptr wraps NUM_KEYS-1→0. Go to S_CHECK.
- A full scan pass takes 2*NUM_KEYS cycles. Worst-case press-to-active latency: 2 sync + 2*NUM_KEYS cycles. An octave change reaches every held voice within one pass.
- Pending keys (pressed, unowned, no voice free) are retried every pass, so they sound once a voice frees. No key is ever owned by two voices.
- Per-voice divider:
  - if active and div≠0: counter increments; when counter==div, counter←0 and tone toggles. Half-period is div+1 cycles.
  - div==0 or inactive: tone held 0, counter held 0.
- mix = registered popcount(tone), 1-cycle latency.
- pwm_cnt counts 0..NUM_VOICES-1 and wraps. pwm_out = registered (pwm_cnt < mix).
  - mix=0 → constant 0.
  - mix=NUM_VOICES → constant 1.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: in S_CHECK, unowned pressed key with no free voice steals voice steal_ptr. In S_LOAD that voice is reassigned as an allocate (counter/tone reset). steal_ptr then increments mod NUM_VOICES. The displaced key becomes pending.
- Undefined: no stealing; steal_ptr absent; the key waits as described above.

Test Plan:
- Reset mid-tone: bench LUT div=10*(k+1); hold key 3, wait until voice 0 tone=1, assert rstn=0 → all outputs 0 asynchronously, FSM restarts at key 0.
- Single key: bench LUT div=10*(k+1); keys=12'h008 → voice 0 active within 26 cycles, owner=3, tone half-period 41 cycles, mix alternates 0/1.
- Release: drop key 3 → voice_active[0]=0 within one pass, tone=0, mix=0, pwm_out=0.
- Five keys with NUM_VOICES=4, VOICE_STEAL_EN off: keys 0,2,4,6,8 pressed → voices 0–3 own keys 0,2,4,6; key 8 silent. Release key 2 → voice 1 takes key 8 within one pass.
- Same five keys, VOICE_STEAL_EN on: key 8 steals voice 0, steal_ptr=1; key 0 then steals voice 1 on the next pass. Check owners every pass, and that no key is ever owned by two voices.
- Octave change: hold key 0 and set octave 4→5 with bench LUT div=100>>(octave-4) → voice 0 div becomes 50 within one pass, no glitch to inactive; all four voices running gives mix ≤4, and pwm_out duty matches mix/4.
